// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution engine and its result consumers.
//   conv_state_t        - frame state of the result streamer
//   out_rows/out_cols   - valid-convolution output dimensions
//   out_total           - output beats per frame
//   cnt_width           - counter width able to index 0..n-1 (never below 1)
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } conv_state_t;

  function automatic int out_rows(input int image_row, input int filter_row);
    return image_row - filter_row + 1;
  endfunction

  function automatic int out_cols(input int image_col, input int filter_col);
    return image_col - filter_col + 1;
  endfunction

  function automatic int out_total(input int image_row, input int image_col,
                                   input int filter_row, input int filter_col);
    return out_rows(image_row, filter_row) * out_cols(image_col, filter_col);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with binary read/write pointers carrying an
// extra wrap bit to tell full from empty.
// Ports:
//   clk, reset (async, active-low)
//   push, din   - write request and data (ignored when full unless popping)
//   pop         - read request (ignored when empty)
//   dout        - head entry, valid whenever empty=0
//   full, empty - occupancy flags
module sync_fifo #(
  parameter int dataWidth = 16,
  parameter int fifoDepth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [dataWidth-1:0] din,
  output logic [dataWidth-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(fifoDepth);

  logic [dataWidth-1:0] mem [fifoDepth];
  logic [AW:0]          wr_ptr_reg;
  logic [AW:0]          rd_ptr_reg;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: buffers single-cycle convolution results and
// re-emits them as a valid/ready stream tagged with row/frame markers.
// Ports:
//   clk, reset (async, active-low)
//   convDone_, write_data_output - result strobe and value from the engine
//   fullConvDone                 - engine claims the frame is complete
//   m_data, m_valid, m_ready     - output stream
//   m_rowLast, m_frameLast       - markers for the current head beat
//   frameDone                    - one-cycle pulse after the frameLast handshake
//   overflow, frameError         - sticky error flags, cleared by reset only
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int imageRow     = 220,
  parameter int imageColumn  = 170,
  parameter int filterRow    = 3,
  parameter int filterColumn = 3,
  parameter int dataWidth    = 16,
  parameter int fifoDepth    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 convDone_,
  input  logic [dataWidth-1:0] write_data_output,
  input  logic                 fullConvDone,
  output logic [dataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_rowLast,
  output logic                 m_frameLast,
  output logic                 frameDone,
  output logic                 overflow,
  output logic                 frameError
);

  localparam int OUT_ROWS  = out_rows(imageRow, filterRow);
  localparam int OUT_COLS  = out_cols(imageColumn, filterColumn);
  localparam int OUT_TOTAL = out_total(imageRow, imageColumn, filterRow, filterColumn);
  localparam int ROW_W     = cnt_width(OUT_ROWS);
  localparam int COL_W     = cnt_width(OUT_COLS);
  localparam int IN_W      = cnt_width(OUT_TOTAL + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_COLS - 1);
  localparam logic [IN_W-1:0]  IN_TOTAL = IN_W'(OUT_TOTAL);
  localparam logic [IN_W-1:0]  IN_ONE   = IN_W'(1);

  conv_state_t          state_reg, state_next;
  logic [IN_W-1:0]      in_count_reg, in_count_next;
  logic [COL_W-1:0]     col_reg, col_next;
  logic [ROW_W-1:0]     row_reg, row_next;
  logic                 overflow_reg, frame_error_reg;
  logic                 push, pop, drop, full, empty;
  logic                 row_last, frame_last, mismatch;
  logic [dataWidth-1:0] head;

  sync_fifo #(
    .dataWidth(dataWidth),
    .fifoDepth(fifoDepth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (write_data_output),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign m_valid    = !empty;
  assign pop        = m_valid && m_ready;
  // Once the frame's inputs are all in, anything else is surplus until DONE.
  assign push       = convDone_ && (state_reg != DRAIN) && (!full || pop);
  assign drop       = convDone_ && !push;
  assign row_last   = m_valid && (col_reg == COL_LAST);
  assign frame_last = row_last && (row_reg == ROW_LAST);
  // DRAIN/DONE imply the count already reached OUT_TOTAL, so they never mismatch.
  assign mismatch   = fullConvDone && (state_reg != DRAIN) && (state_reg != DONE) &&
                      (in_count_reg != IN_TOTAL);

  assign m_data      = m_valid ? head : '0;
  assign m_rowLast   = row_last;
  assign m_frameLast = frame_last;
  assign frameDone   = (state_reg == DONE);
  assign overflow    = overflow_reg;
  assign frameError  = frame_error_reg;

  always_comb begin
    state_next    = state_reg;
    in_count_next = in_count_reg;
    col_next      = col_reg;
    row_next      = row_reg;

    if (pop) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
    if (push) in_count_next = in_count_reg + IN_ONE;

    unique case (state_reg)
      IDLE: begin
        if (push) state_next = (in_count_next == IN_TOTAL) ? DRAIN : ACTIVE;
      end
      ACTIVE: begin
        if (in_count_next == IN_TOTAL) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && frame_last) state_next = DONE;
      end
      DONE: begin
        // FIFO is empty here; a strobe in this cycle opens the next frame.
        col_next      = '0;
        row_next      = '0;
        in_count_next = push ? IN_ONE : '0;
        if (push) state_next = (IN_ONE == IN_TOTAL) ? DRAIN : ACTIVE;
        else      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      in_count_reg    <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      overflow_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_count_reg <= in_count_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      if (drop)     overflow_reg    <= 1'b1;
      if (mismatch) frame_error_reg <= 1'b1;
    end
  end

endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Transmit side of the convolution result interface. Accepts the single-cycle result strobe (`convDone_` with `write_data_output`) from `single_convolution` and buffers it in a small FIFO. Re-emits each result as a valid/ready stream beat tagged with end-of-row and end-of-frame markers, so results can reach a DMA, a UART bridge or the next layer without dropping data under back-pressure. Sits between the convolution engine and any downstream consumer.

## Interface
- `imageRow`, 220, input image rows
- `imageColumn`, 170, input image columns
- `filterRow`, 3, filter rows
- `filterColumn`, 3, filter columns
- `dataWidth`, 16, result width (signed two's complement, passed through untouched)
- `fifoDepth`, 8, buffer entries; must be a power of 2 and at least 2
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `convDone_`  in  1  result strobe, one cycle per result
- `write_data_output`  in  dataWidth  result, valid when `convDone_`=1
- `fullConvDone`  in  1  engine reports the whole frame is finished
- `m_data`  out  dataWidth  stream data
- `m_valid`  out  1  beat available
- `m_ready`  in  1  consumer accepts the beat when `m_valid`&`m_ready`
- `m_rowLast`  out  1  beat is the last column of an output row
- `m_frameLast`  out  1  beat is the last beat of the frame
- `frameDone`  out  1  one-cycle pulse after the frameLast beat is accepted
- `overflow`  out  1  sticky: a strobe was dropped
- `frameError`  out  1  sticky: `fullConvDone` arrived with an input count ≠ OUT_TOTAL

## Operation
- Derived values:
  - OUT_ROWS = imageRow−filterRow+1.
  - OUT_COLS = imageColumn−filterColumn+1.
  - OUT_TOTAL = OUT_ROWS·OUT_COLS (218·168 = 36624 at defaults).
  - Counter widths use $clog2 of these values.
- Push: `convDone_`=1 writes `write_data_output` into the FIFO and increments the input count.
- Pop: `m_valid`&`m_ready` removes the head entry and advances the output column/row counters.
- Markers are computed from the output counters of the head beat:
  - `m_rowLast` = (col == OUT_COLS−1).
  - `m_frameLast` = rowLast & (row == OUT_ROWS−1).
- Full FIFO with push and no pop: the strobe is dropped, `overflow` is set, and the input count does not increment.
- Full FIFO with push and pop in the same cycle: both occur, no overflow.
- Empty FIFO: a push alone is accepted. There is no combinational bypass.
- State machine:
  - IDLE: counters zero. The first push moves to ACTIVE.
  - ACTIVE: input count reaching OUT_TOTAL moves to DRAIN.
  - DRAIN: further strobes are dropped and set `overflow`. Acceptance of the frameLast beat moves to DONE.
  - DONE: `frameDone`=1 for one cycle, all counters clear, then IDLE.
- `fullConvDone`:
  - Checked on every cycle it is high, in any state.
  - If the input count ≠ OUT_TOTAL (or OUT_TOTAL already rolled into DRAIN/DONE, which is a match), `frameError` is set.
  - The state is never altered by `fullConvDone`.
- `overflow` and `frameError` clear only on reset.

## Timing
- Reset (asynchronous, active-low) forces all outputs and state to zero: `m_valid`, `m_rowLast`, `m_frameLast`, `frameDone`, `overflow`, `frameError` = 0, `m_data` = 0, state IDLE, FIFO empty.
- Reset asserted mid-frame discards the FIFO contents and all counts.
- Latency: a strobe in cycle N into an empty FIFO gives `m_valid`=1 in cycle N+1.
- Sustained throughput: one beat per cycle with `m_ready`=1.
- `m_data`, `m_rowLast` and `m_frameLast` are stable while `m_valid`=1 and `m_ready`=0.
- `m_valid` never drops without a handshake.
- `frameDone` is asserted in the cycle after the frameLast handshake.
- A new frame's first strobe may arrive in the DONE cycle. It is accepted into the FIFO and counted as input 1 of the new frame, and the state goes to ACTIVE.

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE, ACTIVE, DRAIN, DONE);
  - constant functions for OUT_ROWS, OUT_COLS and OUT_TOTAL, reused by the engine and other consumers.
- Sub-module `sync_fifo`:
  - parameters dataWidth and fifoDepth;
  - ports push, pop, din, dout, full, empty;
  - gray-free binary pointers with an extra wrap bit.
- Counters, markers and the FSM live in the top module.

## Test plan
Bench parameters: imageRow=5, imageColumn=4, filter 3×3, so OUT = 3×2, 6 beats; fifoDepth=4.
- **Back-to-back, no back-pressure.** Stimulus: 6 strobes with values 1…6, `m_ready`=1. Required: 6 beats in order, each one cycle after its strobe; `m_rowLast` on beats 2, 4 and 6; `m_frameLast` only on beat 6; `frameDone` pulses in the following cycle.
- **Stalled consumer.** Stimulus: `m_ready`=0, strobes −1, −2, −3, −4, then `m_ready`=1. Required: beats −1…−4 in order with signed values intact, and no overflow.
- **Overflow.** Stimulus: `m_ready`=0, 5 strobes. Required: the 5th is dropped and `overflow`=1 is held; the first 4 beats still emerge correctly.
- **Full with simultaneous push and pop.** Stimulus: FIFO full, a strobe arrives in the same cycle as a handshake. Required: no overflow, and the occupancy stays at 4.
- **Short frame.** Stimulus: `fullConvDone` after 5 strobes. Required: `frameError`=1; the FSM stays in ACTIVE; the 6th strobe still completes the frame with `frameDone`.
- **Reset mid-frame.** Stimulus: reset pulsed low after 3 strobes with `m_ready`=0. Required: all outputs are 0 immediately, and the next 6 strobes form a clean frame.
